// File: rtl/bcd_display_driver.sv
// Four-slot multiplexed 7-segment driver for a signed three-digit BCD value.
// Slot order: ones, tens, hundreds, sign. Each slot is driven for REFRESH_DIV
// cycles followed by GAP_CYCLES of all-off. New values are double-buffered and
// only committed at a frame boundary so a frame is never torn.
// Optional leading-zero blanking: define BCD_LEADING_ZERO_BLANK_EN.
module bcd_display_driver #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GAP_CYCLES  = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] ten_0,
  input  logic [3:0] ten_1,
  input  logic [3:0] ten_2,
  input  logic [3:0] signal,
  input  logic       load,
  output logic       pending,
  output logic [6:0] seg,
  output logic [3:0] an
);

`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam bit LzbEn = 1'b1;
`else
  localparam bit LzbEn = 1'b0;
`endif

  localparam int unsigned MaxCnt = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] DriveLast = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(GAP_CYCLES - 1);

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [3:0] AnOff    = 4'b1111;

  typedef enum logic [1:0] {StIdle, StDrive, StGap} state_e;

  state_e          state_q;
  logic [1:0]      index_q;
  logic [CntW-1:0] cnt_q;
  logic [15:0]     pend_val_q;
  logic [15:0]     disp_q;

  // Digit encoding, {g,f,e,d,c,b,a} active-low; non-BCD codes blank.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Segment pattern for one slot of a packed {sign, hundreds, tens, ones} value.
  function automatic logic [6:0] slot_seg(input logic [15:0] v, input logic [1:0] idx);
    logic [6:0] s;
    case (idx)
      2'd0: s = seg_digit(v[3:0]);
      2'd1: s = (LzbEn && v[11:8] == 4'd0 && v[7:4] == 4'd0) ? SegBlank : seg_digit(v[7:4]);
      2'd2: s = (LzbEn && v[11:8] == 4'd0) ? SegBlank : seg_digit(v[11:8]);
      default: s = (v[15:12] == 4'b1010) ? 7'b0111111 : SegBlank;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] slot_an(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  logic [15:0] in_val;
  logic [1:0]  next_index;
  logic        frame_commit;
  logic [15:0] next_disp;

  assign in_val       = {signal, ten_2, ten_1, ten_0};
  assign next_index   = index_q + 2'd1;
  // Frame boundary: leaving the sign slot's gap with a value waiting.
  assign frame_commit = (index_q == 2'd3) && pending;
  assign next_disp    = frame_commit ? pend_val_q : disp_q;

  // Scan FSM, buffers and registered outputs; outputs are loaded with the
  // pattern for the state being entered so they line up with the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      index_q    <= 2'd0;
      cnt_q      <= '0;
      pend_val_q <= 16'h0000;
      disp_q     <= 16'h0000;
      pending    <= 1'b0;
      an         <= AnOff;
      seg        <= SegBlank;
    end else begin
      unique case (state_q)
        StIdle: begin
          an  <= AnOff;
          seg <= SegBlank;
          if (load) begin
            disp_q  <= in_val;
            pending <= 1'b0;
            state_q <= StDrive;
            index_q <= 2'd0;
            cnt_q   <= '0;
            an      <= slot_an(2'd0);
            seg     <= slot_seg(in_val, 2'd0);
          end
        end
        StDrive: begin
          if (cnt_q == DriveLast) begin
            cnt_q   <= '0;
            state_q <= StGap;
            an      <= AnOff;
            seg     <= SegBlank;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (load) begin
            pend_val_q <= in_val;
            pending    <= 1'b1;
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            cnt_q   <= '0;
            state_q <= StDrive;
            index_q <= next_index;
            disp_q  <= next_disp;
            an      <= slot_an(next_index);
            seg     <= slot_seg(next_disp, next_index);
            if (frame_commit) pending <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
          // A load on the commit cycle refills the buffer and keeps pending set.
          if (load) begin
            pend_val_q <= in_val;
            pending    <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          an      <= AnOff;
          seg     <= SegBlank;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver with REFRESH_DIV=4, GAP_CYCLES=2.
// Expected values follow BCD_LEADING_ZERO_BLANK_EN the same way as the design.
module tb_bcd_display_driver;

  localparam int RD = 4;
  localparam int GC = 2;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SM = 7'b0111111;
`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = SB;
`else
  localparam logic [6:0] LZ = S0;
`endif

  localparam logic [3:0] A0 = 4'b1110;
  localparam logic [3:0] A1 = 4'b1101;
  localparam logic [3:0] A2 = 4'b1011;
  localparam logic [3:0] A3 = 4'b0111;
  localparam logic [3:0] AO = 4'b1111;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load  = 1'b0;
  logic [3:0] ten_0 = 4'd0;
  logic [3:0] ten_1 = 4'd0;
  logic [3:0] ten_2 = 4'd0;
  logic [3:0] signal = 4'd0;
  logic       pending;
  logic [6:0] seg;
  logic [3:0] an;

  int vectors = 0;
  int errors  = 0;

  bcd_display_driver #(.REFRESH_DIV(RD), .GAP_CYCLES(GC)) dut (
    .clock   (clock),
    .reset   (reset),
    .ten_0   (ten_0),
    .ten_1   (ten_1),
    .ten_2   (ten_2),
    .signal  (signal),
    .load    (load),
    .pending (pending),
    .seg     (seg),
    .an      (an)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_val(input logic [3:0] s, input logic [3:0] h, input logic [3:0] t,
                         input logic [3:0] o);
    signal = s;
    ten_2  = h;
    ten_1  = t;
    ten_0  = o;
  endtask

  // One scan slot: RD drive cycles then GC gap cycles. Optional load strobe on
  // drive cycle ld_cycle, or on the last gap cycle (the slot-exit edge).
  task automatic slot(input string tag, input logic [3:0] ea, input logic [6:0] es,
                      input int ld_cycle, input bit ld_gap);
    for (int i = 0; i < RD; i++) begin
      chk({tag, "_an"}, 16'(an), 16'(ea));
      chk({tag, "_seg"}, 16'(seg), 16'(es));
      if (i == ld_cycle) load = 1'b1;
      tick();
      load = 1'b0;
    end
    for (int g = 0; g < GC; g++) begin
      chk({tag, "_gap_an"}, 16'(an), 16'(AO));
      chk({tag, "_gap_seg"}, 16'(seg), 16'(SB));
      if (g == GC - 1 && ld_gap) load = 1'b1;
      tick();
      load = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset and idle for 100 cycles.
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      chk("idle_an", 16'(an), 16'(AO));
      chk("idle_seg", 16'(seg), 16'(SB));
      chk("idle_pend", 16'(pending), 16'd0);
      tick();
    end

    // Load 123 from idle: one full 24-cycle frame.
    set_val(4'd0, 4'd1, 4'd2, 4'd3);
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("l123_pend", 16'(pending), 16'd0);
    slot("f123_s0", A0, S3, -1, 1'b0);
    slot("f123_s1", A1, S2, -1, 1'b0);
    slot("f123_s2", A2, S1, -1, 1'b0);
    slot("f123_s3", A3, SB, -1, 1'b0);
    slot("f123_s0b", A0, S3, -1, 1'b0);

    // Non-BCD codes on digit slots blank.
    do_reset();
    chk("rst1_an", 16'(an), 16'(AO));
    set_val(4'd3, 4'hB, 4'd0, 4'hC);
    load = 1'b1;
    tick();
    load = 1'b0;
    slot("fbad_s0", A0, SB, -1, 1'b0);
    slot("fbad_s1", A1, S0, -1, 1'b0);
    slot("fbad_s2", A2, SB, -1, 1'b0);
    slot("fbad_s3", A3, SB, -1, 1'b0);

    // Minus seven: sign slot and leading zeros.
    do_reset();
    set_val(4'b1010, 4'd0, 4'd0, 4'd7);
    load = 1'b1;
    tick();
    load = 1'b0;
    slot("fm7_s0", A0, S7, -1, 1'b0);
    slot("fm7_s1", A1, LZ, -1, 1'b0);
    slot("fm7_s2", A2, LZ, -1, 1'b0);
    slot("fm7_s3", A3, SM, -1, 1'b0);

    // Mid-frame load during slot 1: current frame finishes with the old value.
    set_val(4'd0, 4'd4, 4'd5, 4'd6);
    slot("fm7b_s0", A0, S7, -1, 1'b0);
    slot("fm7b_s1", A1, LZ, 0, 1'b0);
    chk("mid_pend_s2", 16'(pending), 16'd1);
    slot("fm7b_s2", A2, LZ, -1, 1'b0);
    chk("mid_pend_s3", 16'(pending), 16'd1);
    slot("fm7b_s3", A3, SM, -1, 1'b0);
    chk("mid_pend_wrap", 16'(pending), 16'd0);

    // Frame 456 with two mid-frame loads; only the second reaches the display.
    set_val(4'd0, 4'd8, 4'd8, 4'd8);
    slot("f456_s0", A0, S6, 0, 1'b0);
    set_val(4'd0, 4'd9, 4'd9, 4'd1);
    slot("f456_s1", A1, S5, -1, 1'b0);
    slot("f456_s2", A2, S4, 1, 1'b0);
    slot("f456_s3", A3, SB, -1, 1'b0);
    chk("two_pend_wrap", 16'(pending), 16'd0);

    // Frame 991: load 035 mid-frame, then -789 on the commit cycle.
    set_val(4'd0, 4'd0, 4'd3, 4'd5);
    slot("f991_s0", A0, S1, -1, 1'b0);
    slot("f991_s1", A1, S9, 1, 1'b0);
    set_val(4'b1010, 4'd7, 4'd8, 4'd9);
    slot("f991_s2", A2, S9, -1, 1'b0);
    slot("f991_s3", A3, SB, -1, 1'b1);
    chk("commit_load_pend", 16'(pending), 16'd1);
    slot("f035_s0", A0, S5, -1, 1'b0);
    slot("f035_s1", A1, S3, -1, 1'b0);
    slot("f035_s2", A2, LZ, -1, 1'b0);
    slot("f035_s3", A3, SB, -1, 1'b0);
    chk("f789_pend", 16'(pending), 16'd0);

    // Frame -789, reset during the gap of slot 2 with a load pending.
    set_val(4'd0, 4'd1, 4'd1, 4'd1);
    slot("f789_s0", A0, S9, -1, 1'b0);
    slot("f789_s1", A1, S8, 0, 1'b0);
    chk("f789_pend_ld", 16'(pending), 16'd1);
    for (int i = 0; i < RD; i++) begin
      chk("f789_s2_an", 16'(an), 16'(A2));
      chk("f789_s2_seg", 16'(seg), 16'(S7));
      tick();
    end
    chk("f789_s2_gap_an", 16'(an), 16'(AO));
    set_val(4'd0, 4'd2, 4'd2, 4'd2);
    reset = 1'b1;
    load  = 1'b1;
    tick();
    reset = 1'b0;
    load  = 1'b0;
    chk("gaprst_an", 16'(an), 16'(AO));
    chk("gaprst_seg", 16'(seg), 16'(SB));
    chk("gaprst_pend", 16'(pending), 16'd0);
    for (int i = 0; i < 30; i++) begin
      chk("postrst_an", 16'(an), 16'(AO));
      chk("postrst_seg", 16'(seg), 16'(SB));
      chk("postrst_pend", 16'(pending), 16'd0);
      tick();
    end

    // Back in idle: a load starts a fresh frame immediately.
    set_val(4'd0, 4'd0, 4'd0, 4'd4);
    load = 1'b1;
    tick();
    load = 1'b0;
    slot("f4_s0", A0, S4, -1, 1'b0);
    slot("f4_s1", A1, LZ, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/bcd_display_driver.md
BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit is driven per scan slot (>=2).
REQ-002 SHALL have parameter GAP_CYCLES, default 16, clock cycles all anodes are off between slots (>=1).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports ten_0, ten_1, ten_2  input  4 each  BCD ones, tens, hundreds from the binary-to-decimal stage.
REQ-006 SHALL have port signal  input  4  sign code; 4'b1010 = minus, any other value = blank.
REQ-007 SHALL have port load  input  1  one-cycle strobe; capture the four inputs.
REQ-008 SHALL have port pending  output  1  captured value not yet committed to display.
REQ-009 SHALL have port seg  output  7  {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port an  output  4  anode selects, active-low; an[0]=ones, an[1]=tens, an[2]=hundreds, an[3]=sign.

Function
REQ-011 SHALL hold a pending register (load-side) and a display register (scan-side), 16 bits each.
REQ-012 SHALL, on load, copy ten_0/ten_1/ten_2/signal into the pending register and set pending=1 next cycle; a load while pending=1 overwrites the pending value.
REQ-013 SHALL use FSM states IDLE, DRIVE, GAP; reset enters IDLE.
REQ-014 IDLE: an=4'b1111, seg=7'b1111111; on load, commit the inputs directly to the display register, clear pending, enter DRIVE with index 0 next cycle.
REQ-015 DRIVE: an has exactly one zero bit at position index; seg encodes that digit; stay exactly REFRESH_DIV cycles, then enter GAP.
REQ-016 GAP: an=4'b1111, seg=7'b1111111; stay exactly GAP_CYCLES cycles, then index=(index+1) mod 4 and enter DRIVE.
REQ-017 SHALL commit the pending register to the display register only on the GAP->DRIVE transition where index wraps 3->0, clearing pending in the same cycle; mid-frame loads never tear a frame.
REQ-018 Load coinciding with the commit cycle: the new value goes to pending (pending stays 1); the previously pending value is committed.
REQ-019 Digit encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; codes 10-15 on digit slots = blank 1111111.
REQ-020 Sign slot: 4'b1010 -> 0111111 (segment g only); anything else -> 1111111.
REQ-021 Prescaler and gap counter SHALL be a single counter cleared on every state change; no cycle lost or added at transitions.
REQ-022 Outputs SHALL be registered (change only on clock edges, no combinational path from inputs to seg/an).

Reset
REQ-023 Reset SHALL force state=IDLE, index=0, counter=0, both registers=16'h0000, pending=0, an=4'b1111, seg=7'b1111111 on the next edge.
REQ-024 Reset asserted mid-DRIVE or mid-GAP SHALL abort the frame; pending loads are discarded; reset dominates a simultaneous load.

Configuration
REQ-025 Macro BCD_LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking.
REQ-026 With macro defined: hundreds slot blank when hundreds=0; tens slot blank when hundreds=0 and tens=0; ones never blanked; sign slot unaffected.
REQ-027 Without macro: all three digit slots always show their digit per REQ-019.

Verification (REFRESH_DIV=4, GAP_CYCLES=2)
REQ-028 Reset, no load for 100 cycles -> an=1111, seg=1111111, pending=0 throughout.
REQ-029 Load {signal=0,ten_2=1,ten_1=2,ten_0=3} from IDLE -> an[0] low with seg=0110000 for 4 cycles, gap 2 cycles all-off, then an[1] seg=0100100, an[2] seg=1111001, an[3] seg=1111111; frame period 24 cycles.
REQ-030 Load {1010,0,0,7} -> sign slot 0111111; with macro hundreds/tens slots 1111111, without macro both 1000000.
REQ-031 Load new value while index=1 -> pending=1 until 3->0 wrap; slots 2,3 of current frame keep old value; next frame shows new value.
REQ-032 Two loads mid-frame -> only the second value ever displayed; load on commit cycle -> pending remains 1, value shown one frame later.
REQ-033 Reset asserted during GAP of slot 2 -> next cycle an=1111, pending=0, state IDLE; display stays blank until next load.
